// File: rtl/register_file_seq_if.sv
// Request and bus bundle between the control sequencer and register_file_seq.
// Pair width is always twice DATA_W.
interface register_file_seq_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  // A request transfers on a rising edge where req_valid && req_ready.
  // req_ready depends only on FSM state, never on req_valid. req_* are
  // sampled only on that accept edge; done is a one-cycle pulse and
  // err/inc_carry are meaningful only while done is high.
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [SEL_W-1:0]      req_src;
  logic [SEL_W-1:0]      req_dst;
  logic [DATA_W-1:0]     req_data;
  logic [2*DATA_W-1:0]   req_addr;
  logic [DATA_W-1:0]     data_out;
  logic                  data_oe;
  logic [2*DATA_W-1:0]   addr_out;
  logic                  addr_oe;
  logic                  done;
  logic                  err;
  logic                  inc_carry;

  modport master (
    output req_valid, req_op, req_src, req_dst, req_data, req_addr,
    input  req_ready, data_out, data_oe, addr_out, addr_oe, done, err, inc_carry
  );

  modport slave (
    input  req_valid, req_op, req_src, req_dst, req_data, req_addr,
    output req_ready, data_out, data_oe, addr_out, addr_oe, done, err, inc_carry
  );
endinterface

// File: rtl/register_file_seq.sv
// Sequenced register file: NUM_REGS x DATA_W registers with pair access, each transfer
// runs IDLE->SELECT->LOAD->RELEASE. Define REGFILE_PAIR_INC_EN to build the pair incrementer.
module register_file_seq #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  register_file_seq_if.slave         bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [1:0]                 state_dbg
);
  localparam int PAIRS = NUM_REGS / 2;
  localparam logic [1:0] OP_MOV8 = 2'b00;
  localparam logic [1:0] OP_LD8  = 2'b01;
  localparam logic [1:0] OP_LDP  = 2'b10;
  localparam logic [1:0] OP_INCP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_LOAD, S_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [SEL_W-1:0]    src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2*DATA_W-1:0] addr_q, addr_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic                req_bad;
  logic [DATA_W-1:0]   src_val;
  logic                drive_phase;
  logic                data_oe, addr_oe;
  logic [DATA_W-1:0]   data_drv;
  logic [2*DATA_W-1:0] addr_drv;

`ifdef REGFILE_PAIR_INC_EN
  logic                carry_q, carry_d;
  logic [2*DATA_W-1:0] pair_val;
  logic [2*DATA_W-1:0] pair_inc;

  always_comb begin
    pair_val = '0;
    for (int p = 0; p < PAIRS; p++) begin
      if (dst_q == SEL_W'(p)) pair_val = {regs_q[2*p], regs_q[2*p+1]};
    end
    pair_inc = pair_val + (2*DATA_W)'(1);
  end
`endif

  // Legality is decided once at accept and carried through the sequence in err_q.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_op)
      OP_MOV8: req_bad = (int'(bus.req_src) >= NUM_REGS) || (int'(bus.req_dst) >= NUM_REGS);
      OP_LD8:  req_bad = int'(bus.req_dst) >= NUM_REGS;
      OP_LDP:  req_bad = int'(bus.req_dst) >= PAIRS;
`ifdef REGFILE_PAIR_INC_EN
      OP_INCP: req_bad = int'(bus.req_dst) >= PAIRS;
`else
      OP_INCP: req_bad = 1'b1;
`endif
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    src_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_q == SEL_W'(i)) src_val = regs_q[i];
    end
  end

  assign drive_phase = ((state_q == S_SELECT) || (state_q == S_LOAD)) && !err_q;
  assign data_oe     = drive_phase && !op_q[1];
  assign addr_oe     = drive_phase && op_q[1];
  assign data_drv    = data_oe ? (op_q[0] ? data_q : src_val) : '0;
`ifdef REGFILE_PAIR_INC_EN
  assign addr_drv    = addr_oe ? (op_q[0] ? pair_inc : addr_q) : '0;
`else
  assign addr_drv    = addr_oe ? addr_q : '0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    addr_d  = addr_q;
    err_d   = err_q;
    regs_d  = regs_q;
`ifdef REGFILE_PAIR_INC_EN
    carry_d = carry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_SELECT;
          op_d    = bus.req_op;
          src_d   = bus.req_src;
          dst_d   = bus.req_dst;
          data_d  = bus.req_data;
          addr_d  = bus.req_addr;
          err_d   = req_bad;
`ifdef REGFILE_PAIR_INC_EN
          carry_d = 1'b0;
`endif
        end
      end
      S_SELECT: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_RELEASE;
        // The destination always takes what is actually on the bus this cycle.
        if (!err_q && !op_q[1]) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (dst_q == SEL_W'(i)) regs_d[i] = data_drv;
          end
        end else if (!err_q) begin
          for (int p = 0; p < PAIRS; p++) begin
            if (dst_q == SEL_W'(p)) {regs_d[2*p], regs_d[2*p+1]} = addr_drv;
          end
        end
`ifdef REGFILE_PAIR_INC_EN
        carry_d = !err_q && (op_q == OP_INCP) && (&pair_val);
`endif
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef REGFILE_PAIR_INC_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
`ifdef REGFILE_PAIR_INC_EN
      carry_q <= carry_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.done      = (state_q == S_RELEASE);
  assign bus.err       = (state_q == S_RELEASE) && err_q;
`ifdef REGFILE_PAIR_INC_EN
  assign bus.inc_carry = (state_q == S_RELEASE) && carry_q;
`else
  assign bus.inc_carry = 1'b0;
`endif
  assign bus.data_oe   = data_oe;
  assign bus.addr_oe   = addr_oe;
  assign bus.data_out  = data_drv;
  assign bus.addr_out  = addr_drv;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_register_file_seq.sv
// Directed bench for register_file_seq: a default 8-register DUT and a 6-register DUT.
// Expected values are hand-computed; INCP expectations follow REGFILE_PAIR_INC_EN.
module tb_register_file_seq;
  localparam logic [1:0] MOV8 = 2'b00;
  localparam logic [1:0] LD8  = 2'b01;
  localparam logic [1:0] LDP  = 2'b10;
  localparam logic [1:0] INCP = 2'b11;
`ifdef REGFILE_PAIR_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  register_file_seq_if #(.DATA_W(8), .SEL_W(3)) bus8 ();
  register_file_seq_if #(.DATA_W(8), .SEL_W(3)) bus6 ();

  logic        v8 = 1'b0, v6 = 1'b0;
  logic [1:0]  op = '0;
  logic [2:0]  src = '0, dst = '0;
  logic [7:0]  dat = '0;
  logic [15:0] adr = '0;
  logic [63:0] regq8;
  logic [47:0] regq6;
  logic [1:0]  st8, st6;

  assign bus8.req_valid = v8;
  assign bus8.req_op    = op;
  assign bus8.req_src   = src;
  assign bus8.req_dst   = dst;
  assign bus8.req_data  = dat;
  assign bus8.req_addr  = adr;
  assign bus6.req_valid = v6;
  assign bus6.req_op    = op;
  assign bus6.req_src   = src;
  assign bus6.req_dst   = dst;
  assign bus6.req_data  = dat;
  assign bus6.req_addr  = adr;

  register_file_seq #(.DATA_W(8), .NUM_REGS(8)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .reg_q(regq8), .state_dbg(st8)
  );
  register_file_seq #(.DATA_W(8), .NUM_REGS(6)) u_dut6 (
    .clk(clk), .reset(reset), .bus(bus6), .reg_q(regq6), .state_dbg(st6)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [7:0]  data;
    logic [15:0] addr;
    bit          e_err;
    bit          e_carry;
    int          e_doe;
    int          e_aoe;
    logic [15:0] e_bus;
    logic [63:0] e_regs;
  } vec_t;

  typedef struct {
    bit          acc;
    int          doe;
    int          aoe;
    int          done_cnt;
    int          done_pos;
    logic [15:0] bus;
    bit          err;
    bit          carry;
    logic [63:0] regs;
  } obs_t;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [2:0] s, input logic [2:0] d,
                              input logic [7:0] da, input logic [15:0] ad, input bit ee,
                              input bit ec, input int edoe, input int eaoe,
                              input logic [15:0] eb, input logic [63:0] er);
    vec_t v;
    v.op = o; v.src = s; v.dst = d; v.data = da; v.addr = ad;
    v.e_err = ee; v.e_carry = ec; v.e_doe = edoe; v.e_aoe = eaoe;
    v.e_bus = eb; v.e_regs = er;
    return v;
  endfunction

  // driver: one request on the selected DUT, observing the full 4-cycle sequence
  task automatic do_txn(input bit sel6, input logic [1:0] o, input logic [2:0] s,
                        input logic [2:0] d, input logic [7:0] da, input logic [15:0] ad,
                        output obs_t r);
    int n;
    r = '{acc: 1'b0, doe: 0, aoe: 0, done_cnt: 0, done_pos: -1, bus: '0,
          err: 1'b0, carry: 1'b0, regs: '0};
    @(negedge clk);
    n = 0;
    while (!(sel6 ? bus6.req_ready : bus8.req_ready) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!(sel6 ? bus6.req_ready : bus8.req_ready)) return;
    r.acc = 1'b1;
    op = o; src = s; dst = d; dat = da; adr = ad;
    if (sel6) v6 = 1'b1; else v8 = 1'b1;
    @(negedge clk);
    v6 = 1'b0; v8 = 1'b0;
    // scramble inputs: the captured request must not follow them
    src = ~s; dst = ~d; dat = ~da; adr = ~ad; op = ~o;
    for (int k = 0; k < 4; k++) begin
      if (sel6 ? bus6.data_oe : bus8.data_oe) begin
        r.doe++;
        r.bus = {8'h00, sel6 ? bus6.data_out : bus8.data_out};
      end
      if (sel6 ? bus6.addr_oe : bus8.addr_oe) begin
        r.aoe++;
        r.bus = sel6 ? bus6.addr_out : bus8.addr_out;
      end
      if (sel6 ? bus6.done : bus8.done) begin
        r.done_cnt++;
        r.done_pos = k;
        r.err   = sel6 ? bus6.err : bus8.err;
        r.carry = sel6 ? bus6.inc_carry : bus8.inc_carry;
        r.regs  = sel6 ? {16'h0000, regq6} : regq8;
      end
      if (k < 3) @(negedge clk);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v, input obs_t r);
    chk({tag, "_accepted"}, 64'(r.acc), 64'd1);
    chk({tag, "_done_cnt"}, 64'(r.done_cnt), 64'd1);
    chk({tag, "_done_pos"}, 64'(r.done_pos), 64'd2);
    chk({tag, "_err"}, 64'(r.err), 64'(v.e_err));
    chk({tag, "_carry"}, 64'(r.carry), 64'(v.e_carry));
    chk({tag, "_data_oe_cycles"}, 64'(r.doe), 64'(v.e_doe));
    chk({tag, "_addr_oe_cycles"}, 64'(r.aoe), 64'(v.e_aoe));
    chk({tag, "_bus"}, 64'(r.bus), 64'(v.e_bus));
    chk({tag, "_regs"}, r.regs, v.e_regs);
  endtask

  vec_t vecs[16];

  initial begin
    obs_t r;
    int acc_cyc[3];
    int n_acc, n_done;
    bit upd;

    // stimulus table for the 8-register DUT, starting from all-zero registers
    vecs[0]  = mk(LD8,  0, 2, 8'hC3, 16'h0, 0, 0, 2, 0, 16'h00C3, 64'h0000_0000_00C3_0000);
    vecs[1]  = mk(MOV8, 2, 7, 8'h00, 16'h0, 0, 0, 2, 0, 16'h00C3, 64'hC300_0000_00C3_0000);
    vecs[2]  = mk(LDP,  0, 3, 8'h00, 16'h12FF, 0, 0, 0, 2, 16'h12FF, 64'hFF12_0000_00C3_0000);
    vecs[3]  = mk(INCP, 0, 3, 8'h00, 16'h0, !INC_EN, 0, 0, INC_EN ? 2 : 0,
                  INC_EN ? 16'h1300 : 16'h0000,
                  INC_EN ? 64'h0013_0000_00C3_0000 : 64'hFF12_0000_00C3_0000);
    vecs[4]  = mk(LDP,  0, 3, 8'h00, 16'hFFFF, 0, 0, 0, 2, 16'hFFFF, 64'hFFFF_0000_00C3_0000);
    vecs[5]  = mk(INCP, 0, 3, 8'h00, 16'h0, !INC_EN, INC_EN, 0, INC_EN ? 2 : 0, 16'h0000,
                  INC_EN ? 64'h0000_0000_00C3_0000 : 64'hFFFF_0000_00C3_0000);
    vecs[6]  = mk(LDP,  0, 3, 8'h00, 16'hA55A, 0, 0, 0, 2, 16'hA55A, 64'h5AA5_0000_00C3_0000);
    vecs[7]  = mk(MOV8, 2, 2, 8'h00, 16'h0, 0, 0, 2, 0, 16'h00C3, 64'h5AA5_0000_00C3_0000);
    vecs[8]  = mk(LD8,  0, 0, 8'h5A, 16'h0, 0, 0, 2, 0, 16'h005A, 64'h5AA5_0000_00C3_005A);
    vecs[9]  = mk(LDP,  0, 0, 8'h00, 16'h1234, 0, 0, 0, 2, 16'h1234, 64'h5AA5_0000_00C3_3412);
    vecs[10] = mk(MOV8, 1, 4, 8'h00, 16'h0, 0, 0, 2, 0, 16'h0034, 64'h5AA5_0034_00C3_3412);
    vecs[11] = mk(LDP,  0, 2, 8'h00, 16'h00FF, 0, 0, 0, 2, 16'h00FF, 64'h5AA5_FF00_00C3_3412);
    vecs[12] = mk(INCP, 0, 2, 8'h00, 16'h0, !INC_EN, 0, 0, INC_EN ? 2 : 0,
                  INC_EN ? 16'h0100 : 16'h0000,
                  INC_EN ? 64'h5AA5_0001_00C3_3412 : 64'h5AA5_FF00_00C3_3412);
    vecs[13] = mk(LD8,  0, 3, 8'h77, 16'h0, 0, 0, 2, 0, 16'h0077,
                  INC_EN ? 64'h5AA5_0001_77C3_3412 : 64'h5AA5_FF00_77C3_3412);
    vecs[14] = mk(MOV8, 3, 6, 8'h00, 16'h0, 0, 0, 2, 0, 16'h0077,
                  INC_EN ? 64'h5A77_0001_77C3_3412 : 64'h5A77_FF00_77C3_3412);
    vecs[15] = mk(LDP,  0, 4, 8'h00, 16'hBEEF, 1, 0, 0, 0, 16'h0000,
                  INC_EN ? 64'h5A77_0001_77C3_3412 : 64'h5A77_FF00_77C3_3412);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_regs", regq8, 64'h0);
    chk("rst_ready", 64'(bus8.req_ready), 64'd1);
    chk("rst_oe", {62'h0, bus8.data_oe, bus8.addr_oe}, 64'h0);
    chk("rst_bus", {40'h0, bus8.data_out, bus8.addr_out}, 64'h0);
    chk("rst_flags", {61'h0, bus8.done, bus8.err, bus8.inc_carry}, 64'h0);
    chk("rst_state", 64'(st8), 64'd0);
    reset = 1'b0;

    // reset arriving during LOAD of LD8 A=0x5A aborts it silently
    @(negedge clk);
    op = LD8; dst = 3'd0; dat = 8'h5A; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    @(negedge clk);
    chk("midrst_in_load", 64'(st8), 64'd2);
    reset = 1'b1;
    #1;
    chk("midrst_regs", regq8, 64'h0);
    chk("midrst_ready", 64'(bus8.req_ready), 64'd1);
    chk("midrst_oe", {62'h0, bus8.data_oe, bus8.addr_oe}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus8.done) n_done++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(n_done), 64'd0);
    chk("midrst_regs_after", regq8, 64'h0);

    // table-driven vectors on the default DUT
    for (int i = 0; i < 16; i++) begin
      do_txn(1'b0, vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].data, vecs[i].addr, r);
      check_vec($sformatf("v%0d", i), vecs[i], r);
    end

    // six-register DUT: indices 6,7 and pair 3 do not exist
    do_txn(1'b1, LDP, 3'd0, 3'd2, 8'h00, 16'hABCD, r);
    check_vec("n6_ldp2", mk(LDP, 0, 2, 0, 0, 0, 0, 0, 2, 16'hABCD, 64'h0000_CDAB_0000_0000), r);
    do_txn(1'b1, LD8, 3'd0, 3'd7, 8'h5A, 16'h0, r);
    check_vec("n6_ld8_7", mk(LD8, 0, 7, 0, 0, 1, 0, 0, 0, 16'h0, 64'h0000_CDAB_0000_0000), r);
    do_txn(1'b1, LDP, 3'd0, 3'd3, 8'h00, 16'h1111, r);
    check_vec("n6_ldp3", mk(LDP, 0, 3, 0, 0, 1, 0, 0, 0, 16'h0, 64'h0000_CDAB_0000_0000), r);
    do_txn(1'b1, LD8, 3'd0, 3'd5, 8'h99, 16'h0, r);
    check_vec("n6_ld8_5", mk(LD8, 0, 5, 0, 0, 0, 0, 2, 0, 16'h0099, 64'h0000_99AB_0000_0000), r);

    // back-to-back: req_valid held high across three requests
    n_acc = 0; n_done = 0; upd = 1'b0;
    @(negedge clk);
    op = LD8; dst = 3'd1; dat = 8'h11; v8 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (upd) begin
        upd = 1'b0;
        if (n_acc == 1) begin
          op = MOV8; src = 3'd1; dst = 3'd5;
        end else if (n_acc == 2) begin
          op = LDP; dst = 3'd0; adr = 16'hBEEF;
        end else begin
          v8 = 1'b0;
        end
      end
      if (bus8.done) n_done++;
      if (v8 && bus8.req_ready && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        upd = 1'b1;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 64'(n_acc), 64'd3);
    if (n_acc == 3) begin
      chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
      chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
    end
    chk("b2b_dones", 64'(n_done), 64'd3);
    chk("b2b_regs", regq8, INC_EN ? 64'h5A77_1101_77C3_EFBE : 64'h5A77_1100_77C3_EFBE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
